// File: rtl/des_input_loader.sv
// -----------------------------------------------------------------------------
// des_input_loader
//
// Avalon-MM bus master that loads plaintext into the 3DES accelerator's
// input SRAM through its CSR window. One start pulse produces, in order:
//   - a write of the word count to the file-size register (reg 41)
//   - for every 64-bit word in memory:
//       read the low half and the high half,
//       write them to the data registers (reg 36 = lo, reg 37 = hi),
//       write the go bit (reg 35 = 1),
//       poll reg 35 until its bit 31 (acknowledge) reads back as 1,
//       clear reg 35 (write 0)
//   - a one-cycle done pulse
// If the acknowledge stays low for POLL_LIMIT polls on one word, the block
// clears reg 35, pulses error and returns to idle without asserting done.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   start                   one-cycle command pulse, only looked at in idle
//   src_address             byte address of word 0 (8-byte aligned)
//   word_count              number of 64-bit words to load
//   busy / done / error     status; done and error are one-cycle pulses
//   master_*                Avalon-MM master port
//   dbg_state               current FSM state, for observation only
//
// Avalon handshake: a command (read or write, never both) is presented with
// its address/data and held unchanged while master_waitrequest is high. It
// is accepted on the rising edge where master_waitrequest is low, and the
// FSM moves on so the request drops in the following cycle. A read completes
// on the first master_readdatavalid seen while waiting for that read; valid
// strobes at any other time are ignored. Only one command is ever in flight.
// -----------------------------------------------------------------------------
module des_input_loader #(
  parameter int                        ADDRESSWIDTH = 26,
  parameter int                        DATAWIDTH    = 32,
  parameter logic [ADDRESSWIDTH-1:0]   CSR_BASE     = '0,
  parameter int                        COUNTWIDTH   = 16,
  parameter int                        POLL_LIMIT   = 1024
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [ADDRESSWIDTH-1:0] src_address,
  input  logic [COUNTWIDTH-1:0]   word_count,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [ADDRESSWIDTH-1:0] master_address,
  output logic [DATAWIDTH-1:0]    master_writedata,
  output logic                    master_write,
  output logic                    master_read,
  input  logic [DATAWIDTH-1:0]    master_readdata,
  input  logic                    master_readdatavalid,
  input  logic                    master_waitrequest,
  output logic [3:0]              dbg_state
);

  // Poll counter must be able to hold POLL_LIMIT itself.
  localparam int PCW = $clog2(POLL_LIMIT + 1);

  // CSR register addresses inside the accelerator window.
  localparam logic [ADDRESSWIDTH-1:0] A_CTRL = CSR_BASE + ADDRESSWIDTH'(35 * 4);
  localparam logic [ADDRESSWIDTH-1:0] A_D0   = CSR_BASE + ADDRESSWIDTH'(36 * 4);
  localparam logic [ADDRESSWIDTH-1:0] A_D1   = CSR_BASE + ADDRESSWIDTH'(37 * 4);
  localparam logic [ADDRESSWIDTH-1:0] A_SIZE = CSR_BASE + ADDRESSWIDTH'(41 * 4);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_WR_SIZE   = 4'd1,
    S_RD_LO     = 4'd2,
    S_WT_LO     = 4'd3,
    S_RD_HI     = 4'd4,
    S_WT_HI     = 4'd5,
    S_WR_D0     = 4'd6,
    S_WR_D1     = 4'd7,
    S_WR_GO     = 4'd8,
    S_POLL_RD   = 4'd9,
    S_POLL_WT   = 4'd10,
    S_WR_CLR    = 4'd11,
    S_NEXT      = 4'd12,
    S_FINISH    = 4'd13,
    S_ABORT_CLR = 4'd14,
    S_ERR       = 4'd15
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDRESSWIDTH-1:0] addr_q, addr_d;
  logic [COUNTWIDTH-1:0]   remaining_q, remaining_d;
  logic [COUNTWIDTH-1:0]   index_q, index_d;
  logic [DATAWIDTH-1:0]    lo_q, lo_d;
  logic [DATAWIDTH-1:0]    hi_q, hi_d;
  logic [PCW-1:0]          poll_q, poll_d;

  // Byte address of the current word's low half; wraps modulo 2^ADDRESSWIDTH.
  logic [ADDRESSWIDTH-1:0] word_addr;
  assign word_addr = addr_q + ADDRESSWIDTH'({index_q, 3'b000});

  logic accepted;
  assign accepted = !master_waitrequest;

  logic ack_bit;
  assign ack_bit = master_readdata[31];

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      index_q     <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      poll_q      <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      index_q     <= index_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      poll_q      <= poll_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    index_d     = index_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    poll_d      = poll_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d      = src_address;
          remaining_d = word_count;
          index_d     = '0;
          state_d     = S_WR_SIZE;
        end
      end

      S_WR_SIZE: begin
        if (accepted) begin
          state_d = (remaining_q == '0) ? S_FINISH : S_RD_LO;
        end
      end

      S_RD_LO: if (accepted) state_d = S_WT_LO;

      S_WT_LO: begin
        if (master_readdatavalid) begin
          lo_d    = master_readdata;
          state_d = S_RD_HI;
        end
      end

      S_RD_HI: if (accepted) state_d = S_WT_HI;

      S_WT_HI: begin
        if (master_readdatavalid) begin
          hi_d    = master_readdata;
          state_d = S_WR_D0;
        end
      end

      S_WR_D0: if (accepted) state_d = S_WR_D1;

      S_WR_D1: if (accepted) state_d = S_WR_GO;

      S_WR_GO: begin
        if (accepted) begin
          // Every word gets a fresh poll budget.
          poll_d  = '0;
          state_d = S_POLL_RD;
        end
      end

      S_POLL_RD: if (accepted) state_d = S_POLL_WT;

      S_POLL_WT: begin
        if (master_readdatavalid) begin
          if (ack_bit) begin
            state_d = S_WR_CLR;
          end else begin
            poll_d  = poll_q + PCW'(1);
            state_d = (poll_d == PCW'(POLL_LIMIT)) ? S_ABORT_CLR : S_POLL_RD;
          end
        end
      end

      S_WR_CLR: if (accepted) state_d = S_NEXT;

      S_NEXT: begin
        remaining_d = remaining_q - COUNTWIDTH'(1);
        index_d     = index_q + COUNTWIDTH'(1);
        state_d     = (remaining_d != '0) ? S_RD_LO : S_FINISH;
      end

      S_FINISH: state_d = S_IDLE;

      S_ABORT_CLR: if (accepted) state_d = S_ERR;

      S_ERR: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Bus command decode. Outputs depend on registered state only, so an
  // asynchronous reset drops any pending request at once.
  // ---------------------------------------------------------------------------
  always_comb begin
    master_read      = 1'b0;
    master_write     = 1'b0;
    master_address   = '0;
    master_writedata = '0;

    case (state_q)
      S_WR_SIZE: begin
        master_write     = 1'b1;
        master_address   = A_SIZE;
        master_writedata = DATAWIDTH'(remaining_q);
      end
      S_RD_LO: begin
        master_read    = 1'b1;
        master_address = word_addr;
      end
      S_RD_HI: begin
        master_read    = 1'b1;
        master_address = word_addr + ADDRESSWIDTH'(4);
      end
      S_WR_D0: begin
        master_write     = 1'b1;
        master_address   = A_D0;
        master_writedata = lo_q;
      end
      S_WR_D1: begin
        master_write     = 1'b1;
        master_address   = A_D1;
        master_writedata = hi_q;
      end
      S_WR_GO: begin
        master_write     = 1'b1;
        master_address   = A_CTRL;
        master_writedata = DATAWIDTH'(1);
      end
      S_POLL_RD: begin
        master_read    = 1'b1;
        master_address = A_CTRL;
      end
      S_WR_CLR, S_ABORT_CLR: begin
        master_write     = 1'b1;
        master_address   = A_CTRL;
        master_writedata = '0;
      end
      default: ;
    endcase
  end

  // busy falls in the same cycle that done or error pulses.
  assign busy      = (state_q != S_IDLE) && (state_q != S_FINISH) && (state_q != S_ERR);
  assign done      = (state_q == S_FINISH);
  assign error     = (state_q == S_ERR);
  assign dbg_state = state_q;

endmodule
